instr_fetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of program memory; drives the program memory bus consumer-A side.
- Issues one word-aligned read per cycle, tracks in-flight reads through the fixed memory latency, and buffers returned words in a small FIFO.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Handles branch/jump redirects by squashing stale in-flight and buffered words.

---
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: program-memory read port (consumer A) plus the decode valid/ready handshake.
// master = fetch unit side, slave = memory/decode environment side.
interface instr_fetch_unit_if;
   logic [31:0] mem_addr_out;
   logic        mem_read_request_out;
   logic [31:0] mem_instr_in;
   logic        mem_data_valid_in;
   logic        redirect_in;
   logic [31:0] redirect_pc_in;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        valid_out;
   logic        ready_in;

   modport master (
      output mem_addr_out, mem_read_request_out,
      input  mem_instr_in, mem_data_valid_in,
      input  redirect_in, redirect_pc_in,
      output instr_out, pc_out, valid_out,
      input  ready_in
   );

   modport slave (
      input  mem_addr_out, mem_read_request_out,
      output mem_instr_in, mem_data_valid_in,
      output redirect_in, redirect_pc_in,
      input  instr_out, pc_out, valid_out,
      output ready_in
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: credit-limited word reads into a fixed-latency memory,
// epoch-tagged in-flight tracking for redirect squash, and a small output FIFO.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          FIFO_DEPTH  = 4,
   parameter int          MEM_LATENCY = 2
) (
   input logic                clk_in,
   input logic                rst_n_in,
   instr_fetch_unit_if.master bus
);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CW   = $clog2(FIFO_DEPTH + MEM_LATENCY + 1);
   localparam int SW   = $clog2(MEM_LATENCY + 1);
   localparam int TAIL = MEM_LATENCY - 1;

   logic [31:0]            fetch_pc_q, fetch_pc_d;
   logic                   epoch_q, epoch_d;
   logic [MEM_LATENCY-1:0] st_valid_q, st_valid_d;
   logic [MEM_LATENCY-1:0] st_epoch_q, st_epoch_d;
   logic [31:0]            st_pc_q [MEM_LATENCY];
   logic [31:0]            st_pc_d [MEM_LATENCY];
   logic [31:0]            fifo_instr_q [FIFO_DEPTH];
   logic [31:0]            fifo_pc_q [FIFO_DEPTH];
   logic [PW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [SW-1:0]          settle_q, settle_d;

   logic [PW:0]   fifo_count;
   logic          fifo_empty, fifo_full;
   logic [CW-1:0] in_flight, occupancy;
   logic          issue, push, pop, valid;

   assign fifo_count = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == (PW+1)'(FIFO_DEPTH));

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
         in_flight = in_flight + CW'(st_valid_q[i]);
      end
   end

   // Credits cover every outstanding word, stale ones included, so the FIFO can never overflow.
   assign valid     = !fifo_empty && !bus.redirect_in;
   assign pop       = valid && bus.ready_in;
   assign occupancy = in_flight + CW'(fifo_count) - CW'(pop);
   assign issue     = rst_n_in && !bus.redirect_in && (occupancy < CW'(FIFO_DEPTH));
   assign push      = bus.mem_data_valid_in && !bus.redirect_in &&
                      st_valid_q[TAIL] && (st_epoch_q[TAIL] == epoch_q);

   genvar gi;
   generate
      for (gi = 0; gi < MEM_LATENCY; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign st_valid_d[gi] = issue;
            assign st_epoch_d[gi] = epoch_q;
            assign st_pc_d[gi]    = fetch_pc_q;
         end else begin : g_shift
            assign st_valid_d[gi] = st_valid_q[gi-1];
            assign st_epoch_d[gi] = st_epoch_q[gi-1];
            assign st_pc_d[gi]    = st_pc_q[gi-1];
         end
      end
   endgenerate

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      epoch_d    = epoch_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (bus.redirect_in) begin
         fetch_pc_d = {bus.redirect_pc_in[31:2], 2'b00};
         epoch_d    = ~epoch_q;
         rd_ptr_d   = wr_ptr_q;
      end else begin
         if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
         if (push)  wr_ptr_d   = wr_ptr_q + (PW+1)'(1);
         if (pop)   rd_ptr_d   = rd_ptr_q + (PW+1)'(1);
      end
      // Responses to pre-reset requests may still land for a few cycles after reset.
      settle_d = (settle_q == SW'(MEM_LATENCY)) ? settle_q : settle_q + SW'(1);
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         fetch_pc_q <= RESET_PC;
         epoch_q    <= 1'b0;
         st_valid_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         settle_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         epoch_q    <= epoch_d;
         st_valid_q <= st_valid_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         settle_q   <= settle_d;
      end
   end

   always_ff @(posedge clk_in) begin
      st_epoch_q <= st_epoch_d;
      st_pc_q    <= st_pc_d;
      if (push) begin
         fifo_instr_q[wr_ptr_q[PW-1:0]] <= bus.mem_instr_in;
         fifo_pc_q[wr_ptr_q[PW-1:0]]    <= st_pc_q[TAIL];
      end
      if (rst_n_in && settle_q == SW'(MEM_LATENCY)) begin
         assert (!(bus.mem_data_valid_in && !st_valid_q[TAIL]));
      end
      if (rst_n_in) begin
         assert (!(push && fifo_full && !pop));
      end
   end

   always_comb begin
      bus.mem_addr_out         = fetch_pc_q;
      bus.mem_read_request_out = issue;
      bus.valid_out            = valid;
      bus.instr_out            = '0;
      bus.pc_out               = '0;
      if (!fifo_empty) begin
         bus.instr_out = fifo_instr_q[rd_ptr_q[PW-1:0]];
         bus.pc_out    = fifo_pc_q[rd_ptr_q[PW-1:0]];
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: fixed-latency memory responder plus a per-cycle reference
// model built from request/pop history, driven by directed and random steps.
module tb_instr_fetch_unit;
   localparam int          L        = 2;
   localparam int          D        = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] K        = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus();

   instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(D), .MEM_LATENCY(L)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );

   // Memory: answers every request exactly L cycles later with addr ^ K, regardless of reset.
   logic [L-1:0] mp_valid = '0;
   logic [31:0]  mp_addr [L];
   always @(posedge clk) begin
      mp_valid   <= {mp_valid[L-2:0], bus.mem_read_request_out};
      mp_addr[0] <= bus.mem_addr_out;
      for (int i = 1; i < L; i++) mp_addr[i] <= mp_addr[i-1];
   end
   assign bus.mem_data_valid_in = mp_valid[L-1];
   assign bus.mem_instr_in      = mp_addr[L-1] ^ K;

   int          checks = 0;
   int          errors = 0;
   int          now = 0;
   int          nreq = 0;
   int          req_q[$];
   int          live_start = 0;
   int          pops_live = 0;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] exp_req = RESET_PC;
   bit          prev_rst_n = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: predict outputs from history, compare, then advance the model.
   task automatic tick();
      int inflight, fifo_cnt;
      bit exp_valid, exp_pop, exp_issue;
      @(negedge clk);
      inflight = 0;
      fifo_cnt = 0;
      foreach (req_q[i]) begin
         if (req_q[i] >= now - L) inflight++;
         if (i >= live_start && req_q[i] <= now - L - 1) fifo_cnt++;
      end
      fifo_cnt  = fifo_cnt - pops_live;
      exp_valid = (fifo_cnt > 0) && !bus.redirect_in;
      exp_pop   = exp_valid && bus.ready_in;
      exp_issue = rst_n && !bus.redirect_in && (inflight + fifo_cnt - (exp_pop ? 1 : 0) < D);
      if (bus.mem_read_request_out === 1'b1) nreq++;
      if (!rst_n) begin
         chk("req_in_reset", 32'(bus.mem_read_request_out), 32'd0);
         if (!prev_rst_n) chk("valid_in_reset", 32'(bus.valid_out), 32'd0);
      end else begin
         chk("valid_out", 32'(bus.valid_out), 32'(exp_valid));
         chk("request", 32'(bus.mem_read_request_out), 32'(exp_issue));
         if (exp_issue) chk("mem_addr", bus.mem_addr_out, exp_req);
         if (exp_pop) begin
            chk("pc_out", bus.pc_out, exp_pc);
            chk("instr_out", bus.instr_out, exp_pc ^ K);
            $display("deliver  t=%0d pc=%h instr=%h", now, bus.pc_out, bus.instr_out);
         end
      end
      if (!rst_n) begin
         req_q.delete();
         live_start = 0;
         pops_live  = 0;
         exp_pc     = RESET_PC;
         exp_req    = RESET_PC;
      end else if (bus.redirect_in) begin
         live_start = req_q.size();
         pops_live  = 0;
         exp_pc     = {bus.redirect_pc_in[31:2], 2'b00};
         exp_req    = exp_pc;
         $display("redirect t=%0d pc=%h", now, exp_pc);
      end else begin
         if (exp_issue) begin
            req_q.push_back(now);
            exp_req = exp_req + 32'd4;
         end
         if (exp_pop) begin
            pops_live++;
            exp_pc = exp_pc + 32'd4;
         end
      end
      prev_rst_n = rst_n;
      now++;
      @(posedge clk);
      #1;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      bus.redirect_in    = 1'b1;
      bus.redirect_pc_in = pc;
      tick();
      bus.redirect_in    = 1'b0;
   endtask

   initial begin
      int r;
      rst_n              = 1'b0;
      bus.ready_in       = 1'b0;
      bus.redirect_in    = 1'b0;
      bus.redirect_pc_in = '0;
      repeat (3) tick();
      chk("rst_addr", bus.mem_addr_out, RESET_PC);
      chk("rst_req", 32'(bus.mem_read_request_out), 32'd0);
      chk("rst_valid", 32'(bus.valid_out), 32'd0);
      chk("rst_instr", bus.instr_out, 32'd0);
      chk("rst_pc", bus.pc_out, 32'd0);

      // Streaming with decode always ready.
      rst_n = 1'b1;
      bus.ready_in = 1'b1;
      repeat (20) tick();

      // Decode stalled after reset: the credit rule allows exactly D requests.
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      bus.ready_in = 1'b0;
      nreq = 0;
      repeat (10) tick();
      chk("stall_req_count", 32'(nreq), 32'(D));
      bus.ready_in = 1'b1;
      repeat (10) tick();

      // Redirect with a partly filled pipeline; low address bits must be dropped.
      bus.ready_in = 1'b0;
      repeat (3) tick();
      bus.ready_in = 1'b1;
      tick();
      redirect_to(32'h0000_0103);
      repeat (10) tick();

      // Back-to-back redirects: only the last target is fetched.
      redirect_to(32'h0000_0040);
      redirect_to(32'h0000_0080);
      repeat (10) tick();

      // Address wrap at the top of memory.
      redirect_to(32'hFFFF_FFF8);
      repeat (10) tick();

      // Reset mid-stream with reads outstanding.
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (12) tick();

      // Random mix of stalls, redirects and occasional resets.
      for (int n = 0; n < 600; n++) begin
         r = int'($urandom_range(0, 99));
         bus.ready_in       = ($urandom_range(0, 3) != 0);
         rst_n              = (r >= 2);
         bus.redirect_in    = (r >= 2 && r < 9);
         bus.redirect_pc_in = $urandom;
         if ($urandom_range(0, 3) == 0) bus.redirect_pc_in = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         tick();
      end
      rst_n           = 1'b1;
      bus.redirect_in = 1'b0;
      bus.ready_in    = 1'b1;
      repeat (12) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
